// File: rtl/rv_scoreboard_hazard_if.sv
// rtl/rv_scoreboard_hazard_if.sv - D-stage issue/interlock bundle for rv_scoreboard_hazard
//
// Purpose: groups the decode-stage instruction fields and the stall/flush
// results exchanged between the pipeline control and the hazard unit.
// Ports (i_ = into the hazard unit, o_ = out of it):
//   i_valid_d, i_rs1_d, i_rs2_d, i_use_rs1_d, i_use_rs2_d,
//   i_rd_d, i_regwrite_d, i_kind_d, i_br_taken_e
//   o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_busy_regs, o_stall_cnt
// Modports: master drives the instruction fields, slave is the hazard unit.
interface rv_scoreboard_hazard_if #(
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic            i_valid_d;
  logic [AW-1:0]   i_rs1_d;
  logic [AW-1:0]   i_rs2_d;
  logic            i_use_rs1_d;
  logic            i_use_rs2_d;
  logic [AW-1:0]   i_rd_d;
  logic            i_regwrite_d;
  logic [1:0]      i_kind_d;
  logic            i_br_taken_e;
  logic            o_stall_f;
  logic            o_stall_d;
  logic            o_flush_d;
  logic            o_flush_e;
  logic [NREG-1:0] o_busy_regs;
  logic [31:0]     o_stall_cnt;

  modport master (
    output i_valid_d, i_rs1_d, i_rs2_d, i_use_rs1_d, i_use_rs2_d,
           i_rd_d, i_regwrite_d, i_kind_d, i_br_taken_e,
    input  o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_busy_regs, o_stall_cnt
  );

  modport slave (
    input  i_valid_d, i_rs1_d, i_rs2_d, i_use_rs1_d, i_use_rs2_d,
           i_rd_d, i_regwrite_d, i_kind_d, i_br_taken_e,
    output o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_busy_regs, o_stall_cnt
  );
endinterface

// File: rtl/rv_scoreboard_hazard.sv
// rtl/rv_scoreboard_hazard.sv - countdown-scoreboard hazard/interlock unit
//
// Purpose: per-register countdown scoreboard that interlocks RAW and WAW
// hazards for ALU, load and multi-cycle MUL results, blocks back-to-back MULs
// on a non-pipelined multiplier, squashes on taken branches and counts stall
// cycles.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   hz       rv_scoreboard_hazard_if.slave (D-stage fields in, stall/flush out)
module rv_scoreboard_hazard #(
  parameter int NREG     = 32,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 4,
  parameter int FWD_EN   = 1,
  parameter int MUL_PIPE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rv_scoreboard_hazard_if.slave hz
);
  localparam int AW     = $clog2(NREG);
  // Without forwarding a result is only readable once it reaches the regfile.
  localparam int EXTRA  = (FWD_EN != 0) ? 0 : 3;
  localparam int D_ALU  = ALU_LAT + EXTRA;
  localparam int D_LOAD = LOAD_LAT + EXTRA;
  localparam int D_MUL  = MUL_LAT + EXTRA;
  localparam int D_MAX  = (D_ALU > D_LOAD) ? ((D_ALU > D_MUL) ? D_ALU : D_MUL)
                                           : ((D_LOAD > D_MUL) ? D_LOAD : D_MUL);
  localparam int CW     = (D_MAX < 1) ? 1 : $clog2(D_MAX + 1);

  localparam logic [1:0] KIND_LOAD = 2'd1;
  localparam logic [1:0] KIND_MUL  = 2'd2;

  logic [CW-1:0]   r_cnt [NREG];
  logic [CW-1:0]   r_mul_busy;
  logic [31:0]     r_stall_cnt;

  logic [NREG-1:0] w_busy;
  logic [CW-1:0]   w_dk_m1;
  logic            w_is_mul;
  logic            w_raw;
  logic            w_waw;
  logic            w_struct;
  logic            w_haz;
  logic            w_stall;
  logic            w_iss;

  always_comb begin
    w_busy = '0;
    for (int r = 1; r < NREG; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  // Counter value loaded at issue: the dependent may issue once it reaches 0.
  always_comb begin
    w_dk_m1 = CW'(D_ALU - 1);
    case (hz.i_kind_d)
      KIND_LOAD: w_dk_m1 = CW'(D_LOAD - 1);
      KIND_MUL:  w_dk_m1 = CW'(D_MUL - 1);
      default:   w_dk_m1 = CW'(D_ALU - 1);
    endcase
  end

  assign w_is_mul = (hz.i_kind_d == KIND_MUL);

  assign w_raw = (hz.i_use_rs1_d && (hz.i_rs1_d != '0) && w_busy[hz.i_rs1_d]) ||
                 (hz.i_use_rs2_d && (hz.i_rs2_d != '0) && w_busy[hz.i_rs2_d]);

  // A younger write must not land before an older, slower one to the same rd.
  assign w_waw = hz.i_regwrite_d && (hz.i_rd_d != '0) &&
                 (r_cnt[hz.i_rd_d] > w_dk_m1);

  assign w_struct = (MUL_PIPE == 0) && w_is_mul && (r_mul_busy != '0);

  assign w_haz   = hz.i_valid_d && (w_raw || w_waw || w_struct);
  // A taken branch squashes the D instruction, so stalling it is pointless.
  assign w_stall = w_haz && !hz.i_br_taken_e;
  assign w_iss   = hz.i_valid_d && !w_stall && !hz.i_br_taken_e;

  assign hz.o_stall_f   = w_stall;
  assign hz.o_stall_d   = w_stall;
  assign hz.o_flush_d   = hz.i_br_taken_e;
  assign hz.o_flush_e   = w_haz || hz.i_br_taken_e;
  assign hz.o_busy_regs = w_busy;
  assign hz.o_stall_cnt = r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      r_cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (w_iss && hz.i_regwrite_d && (hz.i_rd_d == AW'(r))) begin
          r_cnt[r] <= w_dk_m1;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mul_busy <= '0;
    end else if (w_iss && w_is_mul && (MUL_PIPE == 0)) begin
      r_mul_busy <= CW'(MUL_LAT - 1);
    end else if (r_mul_busy != '0) begin
      r_mul_busy <= r_mul_busy - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_rv_scoreboard_hazard.sv
// tb/tb_rv_scoreboard_hazard.sv - directed table-driven bench for rv_scoreboard_hazard
module tb_rv_scoreboard_hazard;
  logic clk;
  logic rst_n;

  int checks;
  int failures;

  rv_scoreboard_hazard_if #(.NREG(32)) hz_a ();
  rv_scoreboard_hazard_if #(.NREG(32)) hz_b ();
  rv_scoreboard_hazard_if #(.NREG(32)) hz_c ();

  rv_scoreboard_hazard u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .hz(hz_a));
  rv_scoreboard_hazard #(.MUL_PIPE(1)) u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .hz(hz_b));
  rv_scoreboard_hazard #(.FWD_EN(0)) u_dut_c (.i_clk(clk), .i_rst_n(rst_n), .hz(hz_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic        use1;
    logic [4:0]  rs2;
    logic        use2;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  kind;
    logic        br;
    logic        stall;
    logic        fd;
    logic        fe;
    logic [31:0] busy;
    logic [31:0] scnt;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic use1,
                              input logic [4:0] rs2, input logic use2, input logic [4:0] rd,
                              input logic rw, input logic [1:0] kind, input logic br,
                              input logic stall, input logic fd, input logic fe,
                              input logic [31:0] busy, input logic [31:0] scnt);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.use1 = use1; v.rs2 = rs2; v.use2 = use2;
    v.rd = rd; v.rw = rw; v.kind = kind; v.br = br;
    v.stall = stall; v.fd = fd; v.fe = fe; v.busy = busy; v.scnt = scnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    hz_a.i_valid_d    = v.valid;
    hz_a.i_rs1_d      = v.rs1;
    hz_a.i_use_rs1_d  = v.use1;
    hz_a.i_rs2_d      = v.rs2;
    hz_a.i_use_rs2_d  = v.use2;
    hz_a.i_rd_d       = v.rd;
    hz_a.i_regwrite_d = v.rw;
    hz_a.i_kind_d     = v.kind;
    hz_a.i_br_taken_e = v.br;
  endtask

  task automatic drive_b(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [1:0] kind);
    hz_b.i_valid_d = valid; hz_b.i_rs1_d = rs1; hz_b.i_use_rs1_d = 1'b1;
    hz_b.i_rs2_d = rs2; hz_b.i_use_rs2_d = 1'b1; hz_b.i_rd_d = rd;
    hz_b.i_regwrite_d = 1'b1; hz_b.i_kind_d = kind; hz_b.i_br_taken_e = 1'b0;
  endtask

  task automatic drive_c(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [1:0] kind);
    hz_c.i_valid_d = valid; hz_c.i_rs1_d = rs1; hz_c.i_use_rs1_d = 1'b1;
    hz_c.i_rs2_d = rs2; hz_c.i_use_rs2_d = 1'b1; hz_c.i_rd_d = rd;
    hz_c.i_regwrite_d = 1'b1; hz_c.i_kind_d = kind; hz_c.i_br_taken_e = 1'b0;
  endtask

  initial begin
    int nstall;
    bit done;
    checks = 0;
    failures = 0;

    // mk(valid, rs1,use1, rs2,use2, rd,rw, kind, br,  stall, fd, fe, busy, stall_cnt)
    vecs[0]  = mk(1,  1,1,  0,0,  5,1, 1, 0,  0,0,0, 32'h0,    0);  // lw x5
    vecs[1]  = mk(1,  5,1,  1,1,  6,1, 0, 0,  1,0,1, 32'h20,   0);  // add x6,x5,x1 load-use
    vecs[2]  = mk(1,  5,1,  1,1,  6,1, 0, 0,  0,0,0, 32'h0,    1);  // add issues
    vecs[3]  = mk(1,  1,1,  2,1,  7,1, 2, 0,  0,0,0, 32'h0,    1);  // mul x7
    vecs[4]  = mk(1,  7,1,  7,1,  8,1, 0, 0,  1,0,1, 32'h80,   1);  // sub x8,x7,x7
    vecs[5]  = mk(1,  7,1,  7,1,  8,1, 0, 0,  1,0,1, 32'h80,   2);
    vecs[6]  = mk(1,  7,1,  7,1,  8,1, 0, 0,  1,0,1, 32'h80,   3);
    vecs[7]  = mk(1,  7,1,  7,1,  8,1, 0, 0,  0,0,0, 32'h0,    4);
    vecs[8]  = mk(1,  1,1,  2,1,  9,1, 2, 0,  0,0,0, 32'h0,    4);  // mul x9
    vecs[9]  = mk(1,  1,1,  2,1, 10,1, 2, 0,  1,0,1, 32'h200,  4);  // mul x10 structural
    vecs[10] = mk(1,  1,1,  2,1, 10,1, 2, 0,  1,0,1, 32'h200,  5);
    vecs[11] = mk(1,  1,1,  2,1, 10,1, 2, 0,  1,0,1, 32'h200,  6);
    vecs[12] = mk(1,  1,1,  2,1, 10,1, 2, 0,  0,0,0, 32'h0,    7);
    vecs[13] = mk(0, 10,1, 10,1, 10,1, 2, 0,  0,0,0, 32'h400,  7);  // invalid: no hazard
    vecs[14] = mk(0, 10,1, 10,1, 10,1, 2, 0,  0,0,0, 32'h400,  7);
    vecs[15] = mk(0, 10,1, 10,1, 10,1, 2, 0,  0,0,0, 32'h400,  7);
    vecs[16] = mk(1,  1,1,  0,0,  5,1, 1, 1,  0,1,1, 32'h0,    7);  // lw x5 squashed
    vecs[17] = mk(1,  5,1,  1,1,  6,1, 0, 0,  0,0,0, 32'h0,    7);  // add x6,x5 no stall
    vecs[18] = mk(1,  1,1,  0,0,  0,1, 1, 0,  0,0,0, 32'h0,    7);  // lw x0
    vecs[19] = mk(1,  0,1,  0,1,  3,1, 0, 0,  0,0,0, 32'h0,    7);  // add x3,x0,x0
    vecs[20] = mk(1,  1,1,  2,1, 11,1, 2, 0,  0,0,0, 32'h0,    7);  // mul x11
    vecs[21] = mk(1, 11,1,  1,1, 12,1, 0, 1,  0,1,1, 32'h800,  7);  // hazard + branch
    vecs[22] = mk(1, 11,1,  1,1, 12,1, 0, 0,  1,0,1, 32'h800,  7);
    vecs[23] = mk(1, 11,1,  1,1, 12,1, 0, 0,  1,0,1, 32'h800,  8);
    vecs[24] = mk(1, 11,1,  1,1, 12,1, 0, 0,  0,0,0, 32'h0,    9);
    vecs[25] = mk(1,  1,1,  2,1, 13,1, 2, 0,  0,0,0, 32'h0,    9);  // mul x13
    vecs[26] = mk(1,  1,1,  2,1, 13,1, 0, 0,  1,0,1, 32'h2000, 9);  // add x13: WAW
    vecs[27] = mk(1,  1,1,  2,1, 13,1, 0, 0,  1,0,1, 32'h2000, 10);
    vecs[28] = mk(1,  1,1,  2,1, 13,1, 0, 0,  1,0,1, 32'h2000, 11);
    vecs[29] = mk(1,  1,1,  2,1, 13,1, 0, 0,  0,0,0, 32'h0,    12);

    rst_n = 1'b0;
    drive_a(mk(0, 0,0, 0,0, 0,0, 0, 1, 0,0,0, 0, 0));
    drive_b(0, 0, 0, 0, 0);
    drive_c(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall_d", {31'd0, hz_a.o_stall_d}, 32'd0);
    check("reset_busy", hz_a.o_busy_regs, 32'd0);
    check("reset_stall_cnt", hz_a.o_stall_cnt, 32'd0);
    check("reset_flush_d_follows_br", {31'd0, hz_a.o_flush_d}, 32'd1);
    check("reset_flush_e_follows_br", {31'd0, hz_a.o_flush_e}, 32'd1);
    hz_a.i_br_taken_e = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      drive_a(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d_stall_d", i), {31'd0, hz_a.o_stall_d}, {31'd0, vecs[i].stall});
      check($sformatf("v%0d_stall_f", i), {31'd0, hz_a.o_stall_f}, {31'd0, vecs[i].stall});
      check($sformatf("v%0d_flush_d", i), {31'd0, hz_a.o_flush_d}, {31'd0, vecs[i].fd});
      check($sformatf("v%0d_flush_e", i), {31'd0, hz_a.o_flush_e}, {31'd0, vecs[i].fe});
      check($sformatf("v%0d_busy", i), hz_a.o_busy_regs, vecs[i].busy);
      check($sformatf("v%0d_stall_cnt", i), hz_a.o_stall_cnt, vecs[i].scnt);
      @(posedge clk);
      #1;
    end
    drive_a(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,0, 0, 0));

    // Pipelined MUL: back-to-back independent MULs never stall.
    drive_b(1, 1, 2, 9, 2);
    @(posedge clk); #1;
    drive_b(1, 1, 2, 10, 2);
    @(negedge clk);
    check("mulpipe_second_mul_stall", {31'd0, hz_b.o_stall_d}, 32'd0);
    check("mulpipe_busy_x9", hz_b.o_busy_regs, 32'h200);
    @(posedge clk); #1;
    drive_b(0, 0, 0, 0, 0);
    @(negedge clk);
    check("mulpipe_busy_both", hz_b.o_busy_regs, 32'h600);
    check("mulpipe_stall_cnt", hz_b.o_stall_cnt, 32'd0);
    @(posedge clk); #1;

    // No forwarding: ALU-to-ALU dependence costs 3 cycles.
    drive_c(1, 1, 2, 3, 0);
    @(posedge clk); #1;
    drive_c(1, 3, 1, 4, 0);
    nstall = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (hz_c.o_stall_d) nstall++;
      else done = 1;
      @(posedge clk); #1;
    end
    check("nofwd_issue_within_bound", {31'd0, done}, 32'd1);
    check("nofwd_stall_cycles", nstall, 32'd3);
    drive_c(0, 0, 0, 0, 0);
    @(negedge clk);
    check("nofwd_stall_cnt", hz_c.o_stall_cnt, 32'd3);
    @(posedge clk); #1;

    // Reset in the middle of a MUL-use stall releases everything at once.
    drive_a(mk(1, 1,1, 2,1, 14,1, 2, 0, 0,0,0, 0, 0));
    @(posedge clk); #1;
    drive_a(mk(1, 14,1, 14,1, 15,1, 0, 0, 0,0,0, 0, 0));
    @(negedge clk);
    check("midstall_stall_d", {31'd0, hz_a.o_stall_d}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_stall_d", {31'd0, hz_a.o_stall_d}, 32'd0);
    check("rst_stall_f", {31'd0, hz_a.o_stall_f}, 32'd0);
    check("rst_flush_e", {31'd0, hz_a.o_flush_e}, 32'd0);
    check("rst_busy", hz_a.o_busy_regs, 32'd0);
    check("rst_stall_cnt", hz_a.o_stall_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
